// File: rtl/mul_seq_ctrl_pkg.sv
// Shared constants and types for the sequential RV32M multiply controller.
// Provides operand widths, the iteration count, the func3 codes and the FSM state type.
// Holds no logic; every other mul_seq_ctrl file imports it.
package mul_seq_ctrl_pkg;

    localparam int DATA_W   = 32;
    localparam int CNT_W    = 5;
    localparam int MUL_ITER = 32;

    // RV32M func3 encodings for the multiply group
    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// EX-stage <-> multiply controller bundle: request, operands, flush in; stall, result out.
// master = EX stage (drives request/operands/flush), slave = mul_seq_ctrl.
// Flow control is the stall_o level; result_valid_o is a one-cycle write strobe.
interface mul_seq_ctrl_if;
    import mul_seq_ctrl_pkg::*;

    logic              mul_start_i;
    logic [2:0]        func3_i;
    logic [DATA_W-1:0] op1_i;
    logic [DATA_W-1:0] op2_i;
    logic [4:0]        rd_addr_i;
    logic              flush_i;
    logic              stall_o;
    logic [DATA_W-1:0] result_o;
    logic              result_valid_o;
    logic [4:0]        rd_addr_o;

    modport master (
        output mul_start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  stall_o, result_o, result_valid_o, rd_addr_o
    );

    modport slave (
        input  mul_start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
        output stall_o, result_o, result_valid_o, rd_addr_o
    );

endinterface

// File: rtl/mul_shift_add.sv
// Shift-add datapath: 64-bit accumulator (product high | multiplier) plus multiplicand register.
// One iteration per step strobe; load/negate take effect on the next clock edge.
// No backpressure: strobes are one-hot by construction in the controller (load > step > negate).
// Ports: clk, rst, load/step/negate strobes, mcand_in/mplier_in magnitudes, acc product out.
module mul_shift_add
    import mul_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic                negate,
    input  logic [DATA_W-1:0]   mcand_in,
    input  logic [DATA_W-1:0]   mplier_in,
    output logic [2*DATA_W-1:0] acc
);

    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W:0]   sum;

    // Upper half plus multiplicand when the current multiplier bit is set;
    // the carry bit becomes the new MSB after the right shift.
    always_comb begin
        sum = {1'b0, acc[2*DATA_W-1:DATA_W]};
        if (acc[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand_q <= '0;
        end else if (load) begin
            acc     <= {{DATA_W{1'b0}}, mplier_in};
            mcand_q <= mcand_in;
        end else if (step) begin
            acc <= {sum, acc[DATA_W-1:1]};
        end else if (negate) begin
            acc <= -acc;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential RV32M multiply controller (MUL/MULH/MULHSU/MULHU) with pipeline stall.
// Latency: accept at T, result_valid_o at T+34 (32 CALC cycles, 1 SIGN, 1 DONE).
// Backpressure: stall_o holds EX from the accept cycle through SIGN; drops in DONE and on flush.
// Ports: clk, rst (sync, active-high), bus (slave modport of mul_seq_ctrl_if).
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mul_seq_ctrl_if.slave  bus
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                sel_lo_q;
    logic                neg_q;
    logic [4:0]          rd_q;
    logic [4:0]          rd_out_q;
    logic [DATA_W-1:0]   res_q;

    logic                accept;
    logic                op1_signed;
    logic                op2_signed;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   res_sel;
    logic                done_vld;
    logic                step;
    logic                negate;

    assign accept = (state_q == ST_IDLE) && bus.mul_start_i &&
                    !bus.func3_i[2] && !bus.flush_i;

    assign op1_signed = (bus.func3_i == INST_MULH) || (bus.func3_i == INST_MULHSU);
    assign op2_signed = (bus.func3_i == INST_MULH);

    // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31.
    assign mag1 = (op1_signed && bus.op1_i[DATA_W-1]) ? -bus.op1_i : bus.op1_i;
    assign mag2 = (op2_signed && bus.op2_i[DATA_W-1]) ? -bus.op2_i : bus.op2_i;

    assign step     = (state_q == ST_CALC) && !bus.flush_i;
    assign negate   = (state_q == ST_SIGN) && neg_q && !bus.flush_i;
    assign done_vld = (state_q == ST_DONE) && !bus.flush_i;
    assign res_sel  = sel_lo_q ? acc[DATA_W-1:0] : acc[2*DATA_W-1:DATA_W];

    // Result and rd are driven live in DONE and hold the last written value otherwise.
    assign bus.result_valid_o = done_vld;
    assign bus.result_o       = done_vld ? res_sel : res_q;
    assign bus.rd_addr_o      = done_vld ? rd_q : rd_out_q;

    mul_shift_add u_shift_add (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (step),
        .negate    (negate),
        .mcand_in  (mag1),
        .mplier_in (mag2),
        .acc       (acc)
    );

    always_comb begin
        state_d     = state_q;
        bus.stall_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.stall_o = accept;
                if (accept) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                bus.stall_o = !bus.flush_i;
                if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                bus.stall_o = !bus.flush_i;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                // EX advances while the result writes back; requests here are ignored.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_lo_q <= 1'b0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            rd_out_q <= '0;
            res_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q    <= '0;
                sel_lo_q <= (bus.func3_i == INST_MUL);
                neg_q    <= (op1_signed & bus.op1_i[DATA_W-1]) ^
                            (op2_signed & bus.op2_i[DATA_W-1]);
                rd_q     <= bus.rd_addr_i;
            end else if (state_q == ST_CALC) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done_vld) begin
                res_q    <= res_sel;
                rd_out_q <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed RV32M corner cases, random operands,
// flush, reset mid-operation, ignored divide requests and back-to-back issue.
// Expected products come from a 64-bit arithmetic reference, not from the DUT.
module tb_mul_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mul_seq_ctrl_if bus ();

    mul_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sign- or zero-extend each operand per instruction, multiply, pick the half.
    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        bx = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ax * bx;
        return (f == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.mul_start_i = 1'b0; bus.func3_i = '0; bus.op1_i = '0; bus.op2_i = '0;
        bus.rd_addr_i = '0; bus.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.result_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.result_valid_o); end
        checks++; if (bus.result_o !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
        checks++; if (bus.rd_addr_o !== 5'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", bus.rd_addr_o); end
        rst = 1'b0;
    endtask

    // Issue one multiply and follow it to write-back, checking stall, latency, result and rd.
    task automatic do_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        logic [31:0] exp_res, got_res;
        logic [4:0]  got_rd;
        logic        stall_at_done;
        int          lat;
        bit          seen, stall_bad;
        exp_res = ref_mul(f, a, b);
        got_res = 'x; got_rd = 'x; stall_at_done = 1'bx;
        @(posedge clk); #1;
        bus.mul_start_i = 1'b1; bus.func3_i = f; bus.op1_i = a; bus.op2_i = b;
        bus.rd_addr_i = rd; bus.flush_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL %s accept_stall got=%b exp=1", tag, bus.stall_o); end
        lat = 0; seen = 0; stall_bad = 0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            bus.mul_start_i = 1'b0;
            bus.op1_i = $urandom; bus.op2_i = $urandom; bus.rd_addr_i = 5'($urandom);
            #1;
            if (bus.result_valid_o === 1'b1) begin
                seen = 1; got_res = bus.result_o; got_rd = bus.rd_addr_o; stall_at_done = bus.stall_o;
            end else if (bus.stall_o !== 1'b1) begin
                stall_bad = 1;
            end
        end
        checks++; if (lat != 34 || !seen) begin failures++; $display("FAIL %s latency got=%0d seen=%0d exp=34", tag, lat, seen); end
        checks++; if (got_res !== exp_res) begin failures++; $display("FAIL %s result got=%h exp=%h", tag, got_res, exp_res); end
        checks++; if (got_rd !== rd) begin failures++; $display("FAIL %s rd got=%h exp=%h", tag, got_rd, rd); end
        checks++; if (stall_at_done !== 1'b0) begin failures++; $display("FAIL %s done_stall got=%b exp=0", tag, stall_at_done); end
        checks++; if (stall_bad) begin failures++; $display("FAIL %s stall_gap got=0 exp=1 during busy", tag); end
        @(posedge clk); #2;
        checks++; if (bus.result_valid_o !== 1'b0) begin failures++; $display("FAIL %s valid_width got=%b exp=0", tag, bus.result_valid_o); end
        checks++; if (bus.result_o !== exp_res) begin failures++; $display("FAIL %s result_hold got=%h exp=%h", tag, bus.result_o, exp_res); end
    endtask

    task automatic test_directed();
        do_mul(3'b000, 32'd7,        32'd6,        5'd9,  "mul_7x6");
        do_mul(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  "mulhu_ff");
        do_mul(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  "mulh_ff");
        do_mul(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  "mul_ff");
        do_mul(3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  "mulhsu_neg");
        do_mul(3'b001, 32'h80000000, 32'h80000000, 5'd5,  "mulh_min");
        do_mul(3'b001, 32'h0,        32'hFFFFFFFF, 5'd6,  "mulh_zero_neg");
        do_mul(3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd31, "mulhsu_min");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom;
            if (i % 4 == 1) a = 32'h80000000;
            if (i % 5 == 2) b = 32'hFFFFFFFF;
            do_mul(3'($urandom_range(0, 3)), a, b, 5'($urandom), "random");
        end
    endtask

    task automatic test_flush();
        bit valid_seen;
        valid_seen = 0;
        @(posedge clk); #1;
        bus.mul_start_i = 1'b1; bus.func3_i = 3'b000; bus.op1_i = 32'd3; bus.op2_i = 32'd5;
        bus.rd_addr_i = 5'd7; bus.flush_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            bus.mul_start_i = 1'b0;
            if (i == 10) bus.flush_i = 1'b1;
            #1;
            if (bus.result_valid_o === 1'b1) valid_seen = 1;
        end
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall_o); end
        checks++; if (valid_seen) begin failures++; $display("FAIL flush_valid got=1 exp=0"); end
        do_mul(3'b000, 32'd1234, 32'd5678, 5'd12, "after_flush");
        // Flush in the same cycle as a request: flush wins, nothing starts.
        @(posedge clk); #1;
        bus.mul_start_i = 1'b1; bus.func3_i = 3'b011; bus.op1_i = 32'd9; bus.op2_i = 32'd9;
        bus.flush_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL flush_accept_stall got=%b exp=0", bus.stall_o); end
        @(posedge clk); #1;
        bus.mul_start_i = 1'b0; bus.flush_i = 1'b0;
        // A divide request would stall only if the block had gone busy.
        bus.func3_i = 3'b100;
        bus.mul_start_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL flush_accept_idle got=%b exp=0", bus.stall_o); end
        bus.mul_start_i = 1'b0;
    endtask

    task automatic test_reset_mid(input bit with_flush);
        bit bad;
        bad = 0;
        @(posedge clk); #1;
        bus.mul_start_i = 1'b1; bus.func3_i = 3'b011; bus.op1_i = 32'hFFFFFFFF; bus.op2_i = 32'hFFFFFFFF;
        bus.rd_addr_i = 5'd17; bus.flush_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            bus.mul_start_i = 1'b0;
        end
        rst = 1'b1; bus.flush_i = with_flush;
        @(posedge clk); #1;
        rst = 1'b0; bus.flush_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL rst_mid_stall flush=%0d got=%b exp=0", with_flush, bus.stall_o); end
        checks++; if (bus.result_o !== 32'h0) begin failures++; $display("FAIL rst_mid_result flush=%0d got=%h exp=0", with_flush, bus.result_o); end
        checks++; if (bus.rd_addr_o !== 5'h0) begin failures++; $display("FAIL rst_mid_rd flush=%0d got=%h exp=0", with_flush, bus.rd_addr_o); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (bus.result_valid_o !== 1'b0 || bus.stall_o !== 1'b0) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rst_mid_quiet flush=%0d got=activity exp=none", with_flush); end
    endtask

    task automatic test_div_ignored();
        bit bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            bus.mul_start_i = 1'b1; bus.func3_i = 3'($urandom_range(4, 7));
            bus.op1_i = $urandom; bus.op2_i = $urandom;
            #1;
            if (bus.result_valid_o !== 1'b0 || bus.stall_o !== 1'b0) bad = 1;
        end
        bus.mul_start_i = 1'b0;
        checks++; if (bad) begin failures++; $display("FAIL div_ignored got=stall_or_valid exp=none"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp_res, r1, r2;
        logic        s_done, s_after;
        int          cyc, v1, v2;
        a = $urandom; b = $urandom;
        exp_res = ref_mul(3'b001, a, b);
        r1 = 'x; r2 = 'x; s_done = 1'bx; s_after = 1'bx;
        @(posedge clk); #1;
        bus.mul_start_i = 1'b1; bus.func3_i = 3'b001; bus.op1_i = a; bus.op2_i = b;
        bus.rd_addr_i = 5'd20; bus.flush_i = 1'b0;
        cyc = 0; v1 = -1; v2 = -1;
        while (v2 < 0 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.result_valid_o === 1'b1) begin
                if (v1 < 0) begin
                    v1 = cyc; r1 = bus.result_o; s_done = bus.stall_o;
                end else begin
                    v2 = cyc; r2 = bus.result_o; bus.mul_start_i = 1'b0;
                end
            end else if (v1 >= 0 && cyc == v1 + 1) begin
                s_after = bus.stall_o;
            end
        end
        bus.mul_start_i = 1'b0;
        checks++; if (v1 != 34) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=34", v1); end
        checks++; if (v2 - v1 != 35) begin failures++; $display("FAIL b2b_gap got=%0d exp=35", v2 - v1); end
        checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL b2b_done_stall got=%b exp=0", s_done); end
        checks++; if (s_after !== 1'b1) begin failures++; $display("FAIL b2b_reaccept_stall got=%b exp=1", s_after); end
        checks++; if (r1 !== exp_res) begin failures++; $display("FAIL b2b_r1 got=%h exp=%h", r1, exp_res); end
        checks++; if (r2 !== exp_res) begin failures++; $display("FAIL b2b_r2 got=%h exp=%h", r2, exp_res); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_div_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32M multiply instructions (MUL, MULH, MULHSU, MULHU).
- The EX stage issues a request. The controller stalls the pipeline while it runs a 32-step shift-add on operand magnitudes, applies sign correction, then returns the selected 32-bit half with a one-cycle valid/write strobe.
- Replaces the single-cycle combinational multiplier in the execute path so that timing closes.

Parameters:
- DATA_W, 32, operand and result width.
- CNT_W, 5, iteration counter width (log2 DATA_W).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- mul_start_i  input  1  request from EX: multiply instruction present.
- func3_i  input  3  RV32M func3. Only 000/001/010/011 are multiplies.
- op1_i  input  DATA_W  rs1 value.
- op2_i  input  DATA_W  rs2 value.
- rd_addr_i  input  5  destination register.
- flush_i  input  1  pipeline flush (jump/branch taken).
- stall_o  output  1  hold PC/IF/ID/EX.
- result_o  output  DATA_W  selected product half.
- result_valid_o  output  1  one-cycle write strobe.
- rd_addr_o  output  5  latched destination register.

Behaviour:
- States: IDLE, CALC, SIGN, DONE.
- Reset (synchronous, highest priority): state=IDLE, counter=0, accumulator=0. Outputs: result_o=0, result_valid_o=0, rd_addr_o=0, stall_o=0.
- Accept: in IDLE, when mul_start_i=1 and func3_i[2]=0 and flush_i=0.
  - Latch func3, rd_addr, and |op1|, |op2| according to signedness:
    - MUL, MULHU: both operands unsigned.
    - MULH: both operands signed.
    - MULHSU: op1 signed, op2 unsigned.
  - Latch neg_flag = XOR of the signs of the signed operands.
  - Go to CALC with counter=0.
  - func3_i[2]=1 (divide ops) is ignored: stay IDLE, no stall.
- CALC: one iteration per cycle on a 64-bit accumulator.
  - If multiplier LSB is 1, add the multiplicand into the upper half.
  - Shift right by 1.
  - Counter increments each cycle. Counter==31 → SIGN. Exactly 32 CALC cycles.
- SIGN: if neg_flag, replace the accumulator with its two's complement (64-bit). → DONE.
- DONE:
  - result_valid_o=1 for this cycle only.
  - result_o = acc[31:0] for MUL, acc[63:32] otherwise.
  - rd_addr_o = latched rd.
  - → IDLE. mul_start_i is ignored in DONE.
- Latency: accept at cycle T → CALC T+1..T+32 → SIGN T+33 → DONE/valid T+34.
- stall_o (combinational):
  - 1 in IDLE when an accept condition is true.
  - 1 throughout CALC and SIGN.
  - 0 in DONE, so EX advances in the same cycle the result writes back.
- result_o and rd_addr_o hold their last values outside DONE. result_valid_o=0 outside DONE.
- Flush: flush_i=1 in any state → IDLE next cycle, no result_valid_o, stall_o=0 in that cycle. Flush beats an accept in the same cycle.
- Simultaneous rst and flush: rst wins, with the same outcome.
- Boundary operands:
  - MULH 0x80000000*0x80000000: magnitude 2^31 handled unsigned, high=0x40000000.
  - Zero operand with negative sign: the SIGN step on 0 yields 0.

Decomposition:
- Shared: func3 codes INST_MUL/INST_MULH/INST_MULHSU/INST_MULHU from the existing instruction defines header.
- New shared constants: state encodings (2-bit), MUL_ITER=32.
- One sub-module: mul_shift_add. It holds the accumulator/multiplicand registers and the iteration step, driven by load/step/negate strobes.
- mul_seq_ctrl holds the FSM, counter, latches and stall logic.

Test Plan:
- MUL 7*6 at T → stall_o=1 T..T+33, result_valid_o=1 at T+34, result_o=0x0000002A, rd_addr_o echoes; stall_o=0 at T+34.
- MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MUL same operands → 0x00000001.
- MULHSU op1=0xFFFFFFFF, op2=2 → 0xFFFFFFFF. MULH 0x80000000*0x80000000 → 0x40000000.
- flush_i at T+10 → IDLE at T+11, stall_o=0, no valid pulse. A new MUL accepted at T+11 completes at T+45.
- rst high at T+20 → all outputs 0 next cycle, state IDLE. mul_start_i with func3=100 → no stall, no valid.
- Back-to-back: mul_start_i held through DONE → ignored in DONE, re-accepted in the following IDLE cycle, second valid 35 cycles after the first.
